// File: rtl/seg7_display_arbiter.sv
// Round-robin owner arbiter for the shared 4-digit seven-segment display.
// Optional macro SEG7_ARB_PREEMPT_EN makes requester 0 a preempting high-priority source.
module seg7_display_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int HCW         = 26
) (
    input  logic                 clock_100Mhz,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      grant,
    output logic [3:0]           s0_src,
    output logic [3:0]           s1_src,
    output logic [3:0]           s2_src,
    output logic [3:0]           s3_src,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);
    localparam int SW = PW + 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0]  LAST_INIT = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_OPEN
    } state_t;

    state_t          state_reg, state_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [PW-1:0]   owner_reg, owner_next;
    logic [PW-1:0]   last_reg, last_next;
    logic [HCW-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [15:0]     digits_reg, digits_next;

    logic [15:0]     req_word [NREQ];
    logic [PW-1:0]   search_idx [NREQ];
    logic [NREQ-1:0] cand;
    logic            found;
    logic [PW-1:0]   sel;
    logic            hold_done;
    logic            preempt_take;

    // search_idx[k] = (last + k + 1) mod NREQ, wrapped by one explicit subtraction
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_search
            logic [SW-1:0] sum;
            assign req_word[gi]   = req_data[16*gi +: 16];
            assign sum            = {1'b0, last_reg} + SW'(gi + 1);
            assign search_idx[gi] = (sum >= SW'(NREQ)) ? PW'(sum - SW'(NREQ)) : sum[PW-1:0];
        end
    endgenerate

    // The current owner never competes with itself for a handover.
    assign cand = req & ~grant_reg;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && cand[search_idx[k]]) begin
                found = 1'b1;
                sel   = search_idx[k];
            end
        end
    end

    assign hold_done = (state_reg == ST_OPEN) || (hold_cnt_reg == HOLD_LAST);

`ifdef SEG7_ARB_PREEMPT_EN
    assign preempt_take = req[0] && (owner_reg != '0);
`else
    assign preempt_take = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        owner_next    = owner_reg;
        last_next     = last_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (found) begin
                    grant_next    = NREQ'(1) << sel;
                    owner_next    = sel;
                    last_next     = sel;
                    hold_cnt_next = '0;
                    state_next    = ST_HOLD;
                end
            end
            ST_HOLD, ST_OPEN: begin
                if (preempt_take) begin
                    // last is left alone so round-robin resumes after the alarm
                    grant_next    = NREQ'(1);
                    owner_next    = '0;
                    hold_cnt_next = '0;
                    state_next    = ST_HOLD;
                end else if (!hold_done) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                    if (hold_cnt_reg == HOLD_LAST - 1'b1) begin
                        state_next = ST_OPEN;
                    end
                end else if (found) begin
                    grant_next    = NREQ'(1) << sel;
                    owner_next    = sel;
                    last_next     = sel;
                    hold_cnt_next = '0;
                    state_next    = ST_HOLD;
                end else if (req[owner_reg]) begin
                    hold_cnt_next = HOLD_LAST;
                    state_next    = ST_OPEN;
                end else begin
                    grant_next    = '0;
                    hold_cnt_next = '0;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Digits follow whoever owns the display after this edge, but only while it requests.
    always_comb begin
        digits_next = digits_reg;
        if ((|grant_next) && req[owner_next]) begin
            digits_next = req_word[owner_next];
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            owner_reg    <= '0;
            last_reg     <= LAST_INIT;
            hold_cnt_reg <= '0;
            digits_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            owner_reg    <= owner_next;
            last_reg     <= last_next;
            hold_cnt_reg <= hold_cnt_next;
            digits_reg   <= digits_next;
        end
    end

    assign grant  = grant_reg;
    assign busy   = |grant_reg;
    assign s0_src = digits_reg[3:0];
    assign s1_src = digits_reg[7:4];
    assign s2_src = digits_reg[11:8];
    assign s3_src = digits_reg[15:12];

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Bench for seg7_display_arbiter: per-cycle ownership model plus directed literal checks.
module tb_seg7_display_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [16*NREQ-1:0] req_data;
    logic [NREQ-1:0] grant;
    logic [3:0]      s0, s1, s2, s3;
    logic            busy;

    int total = 0;
    int bad   = 0;

    seg7_display_arbiter #(
        .NREQ(NREQ),
        .HOLD_CYCLES(HOLD),
        .HCW(4)
    ) dut (
        .clock_100Mhz(clk),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .grant(grant),
        .s0_src(s0),
        .s1_src(s1),
        .s2_src(s2),
        .s3_src(s3),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_owner = -1;   // -1 means nobody owns the display
    int          m_age   = 0;    // edges since the owner was granted
    int          m_last  = NREQ - 1;
    logic [15:0] m_disp  = '0;
    bit          m_valid = 1'b0;
    int          n;

    function automatic int pick(int from, int excl);
        for (int k = 1; k <= NREQ; k++) begin
            int i = (from + k) % NREQ;
            if (req[i] && i != excl) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_owner = -1;
            m_age   = 0;
            m_last  = NREQ - 1;
            m_disp  = '0;
            m_valid = 1'b1;
        end else begin
            if (m_owner < 0) begin
                n = pick(m_last, -1);
                if (n >= 0) begin
                    m_owner = n;
                    m_last  = n;
                    m_age   = 0;
                end
            end
`ifdef SEG7_ARB_PREEMPT_EN
            else if (req[0] && m_owner != 0) begin
                m_owner = 0;
                m_age   = 0;
            end
`endif
            else if (m_age + 1 < HOLD) begin
                m_age++;
            end else begin
                m_age++;
                n = pick(m_last, m_owner);
                if (n >= 0) begin
                    m_owner = n;
                    m_last  = n;
                    m_age   = 0;
                end else if (!req[m_owner]) begin
                    m_owner = -1;
                end
            end
            if (m_owner >= 0 && req[m_owner]) m_disp = req_data[m_owner*16 +: 16];
        end
    end

    always @(negedge clk) begin
        logic [3:0] eg;
        if (m_valid) begin
            eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            check("cyc_grant", grant, eg);
            check("cyc_busy", busy, m_owner >= 0);
            check("cyc_digits", {s3, s2, s1, s0}, m_disp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int cnt = 1);
        repeat (cnt) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick(2);
        reset = 1'b0;
    endtask

    logic [3:0] seq_grant[$];
    int         seq_time[$];
    logic [3:0] prev;

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        tick(3);
        check("reset_grant", grant, 4'b0000);
        check("reset_digits", {s3, s2, s1, s0}, 16'h0000);
        reset = 1'b0;

        // idle with no requests
        tick(20);
        check("idle_grant", grant, 4'b0000);
        check("idle_busy", busy, 1'b0);
        check("idle_digits", {s3, s2, s1, s0}, 16'h0000);

        // single requester 2
        req_data[47:32] = 16'h1234;
        req = 4'b0100;
        tick();
        check("single_grant", grant, 4'b0100);
        check("single_digits", {s3, s2, s1, s0}, 16'h1234);
        req_data[47:32] = 16'h5678;
        tick();
        check("data_latency", {s3, s2, s1, s0}, 16'h5678);
        tick(2);
        req = 4'b0000;
        tick(4);
        check("hold_min_grant", grant, 4'b0100);
        check("hold_frozen", {s3, s2, s1, s0}, 16'h5678);
        tick();
        check("release_grant", grant, 4'b0000);
        check("release_digits_kept", {s3, s2, s1, s0}, 16'h5678);

        // round robin 0,1,3
        do_reset();
        req_data = {16'h0F08, 16'h0F04, 16'h0F02, 16'h0F01};
        req = 4'b1011;
        prev = 4'b0000;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (grant != prev) begin
                seq_grant.push_back(grant);
                seq_time.push_back(t);
                prev = grant;
            end
        end
        check("rr_changes", seq_grant.size() >= 4, 1'b1);
        if (seq_grant.size() >= 4) begin
            check("rr_order0", seq_grant[0], 4'b0001);
            check("rr_order1", seq_grant[1], 4'b0010);
            check("rr_order2", seq_grant[2], 4'b1000);
            check("rr_order3", seq_grant[3], 4'b0001);
            check("rr_len0", seq_time[1] - seq_time[0], HOLD);
            check("rr_len1", seq_time[2] - seq_time[1], HOLD);
            check("rr_len2", seq_time[3] - seq_time[2], HOLD);
        end

        // owner 1 drops early while requester 3 waits
        do_reset();
        req_data[31:16] = 16'hBEEF;
        req_data[63:48] = 16'hC0DE;
        req = 4'b0010;
        tick();
        check("drop_grant", grant, 4'b0010);
        tick(2);
        req = 4'b1000;
        req_data[31:16] = 16'hDEAD;
        tick(5);
        check("drop_still_owner", grant, 4'b0010);
        check("drop_frozen", {s3, s2, s1, s0}, 16'hBEEF);
        tick();
        check("drop_handover", grant, 4'b1000);
        check("drop_new_digits", {s3, s2, s1, s0}, 16'hC0DE);

        // reset in the middle of a hold
        do_reset();
        req_data[47:32] = 16'h2222;
        req = 4'b0100;
        tick(3);
        reset = 1'b1;
        req = 4'b0110;
        tick();
        check("midreset_grant", grant, 4'b0000);
        check("midreset_digits", {s3, s2, s1, s0}, 16'h0000);
        reset = 1'b0;
        tick();
        check("after_reset_grant", grant, 4'b0010);

        // long owner in open state, immediate handover on a new request
        do_reset();
        req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0A0A};
        req = 4'b1000;
        tick(30);
        check("long_owner", grant, 4'b1000);
        req = 4'b1001;
        tick();
        check("open_handover", grant, 4'b0001);
        check("open_handover_digits", {s3, s2, s1, s0}, 16'h0A0A);

`ifdef SEG7_ARB_PREEMPT_EN
        do_reset();
        req_data = {16'h3333, 16'h2222, 16'h1111, 16'h9999};
        req = 4'b0100;
        tick(3);
        req = 4'b1101;
        tick();
        check("preempt_grant", grant, 4'b0001);
        check("preempt_digits", {s3, s2, s1, s0}, 16'h9999);
        req = 4'b1100;
        tick(7);
        check("preempt_hold", grant, 4'b0001);
        tick();
        check("preempt_resume", grant, 4'b1000);
`endif

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
